// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline control unit for a classic five-stage in-order core. It decides,
// every cycle, which pipeline registers advance, which receive a bubble and
// whether the PC loads. Decisions are combinational from the registered
// state below plus the current stage inputs.
//
// Priority of pipeline events, highest first:
//   1. data-memory stall   (MEM access outstanding, memory not ready)
//   2. branch flush        (taken branch / jump resolved in EX)
//   3. load-use stall      (ID reads the register a load in EX will write)
//   4. instruction wait    (fetch data not valid this cycle)
//   5. wrong-path discard  (fetch that was in flight across a redirect)
//
// Registered state:
//   state        RUN / DMEM_WAIT
//   drop_next    the next fetch response belongs to the pre-redirect path
//   wait_cnt     consecutive data-memory wait cycles, saturating
//   dmem_timeout sticky, set when wait_cnt reaches DMEM_TIMEOUT
//
// Parameters:
//   DMEM_TIMEOUT  data-memory wait cycles before dmem_timeout sets (1..1023)
//   CNT_W         width of the optional performance counters
//
// Optional feature (compile-time macro HAZARD_PERF_COUNTERS_EN):
//   defined   -> stall_count counts cycles with pc_enable=0 out of reset,
//                flush_count counts branch-flush cycles; both wrap.
//   undefined -> both ports are tied to 0 and no counter flops exist.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   r1_reg_idx_id, r2_reg_idx_id    source register indices in ID
//   uses_r1_id, uses_r2_id          ID instruction actually reads rs1/rs2
//   mem_do_read_ctrl_ex             EX instruction is a load
//   wr_reg_idx_ex                   EX destination register index
//   branch_taken_ex                 EX redirects the fetch stream
//   dmem_req_mem, dmem_ready        MEM-stage data-memory handshake
//   imem_ready                      fetch data valid this cycle
//   pc_enable                       PC load enable
//   if_id_enable / if_id_clear      IF/ID register control
//   id_ex_enable / id_ex_clear      ID/EX register control
//   ex_mem_enable                   EX/MEM register enable
//   mem_wb_enable / mem_wb_clear    MEM/WB register control
//   dmem_timeout                    sticky data-memory timeout flag
//   stall_count, flush_count        optional performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int DMEM_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       r1_reg_idx_id,
    input  logic [4:0]       r2_reg_idx_id,
    input  logic             uses_r1_id,
    input  logic             uses_r2_id,
    input  logic             mem_do_read_ctrl_ex,
    input  logic [4:0]       wr_reg_idx_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_clear,
    output logic             id_ex_enable,
    output logic             id_ex_clear,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic             mem_wb_clear,
    output logic             dmem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Elaboration-time guard: the wait counter is 10 bits wide.
    if (DMEM_TIMEOUT < 1 || DMEM_TIMEOUT > 1023) begin : g_bad_timeout
        $error("hazard_ctrl: DMEM_TIMEOUT must be in 1..1023");
    end

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } state_t;

    localparam logic [9:0] TIMEOUT_CNT = 10'(DMEM_TIMEOUT);

    state_t     state;
    logic       drop_next;
    logic [9:0] wait_cnt;
    logic [9:0] wait_cnt_inc;

    logic dmem_stall;
    logic flush;
    logic r1_hit;
    logic r2_hit;
    logic load_use;
    logic drop_done;

    // -------------------------------------------------------------------------
    // Event detection
    // -------------------------------------------------------------------------
    assign dmem_stall = dmem_req_mem && !dmem_ready;

    // A branch seen while MEM is stalled stays asserted because EX is frozen,
    // so the flush simply lands on the release cycle without extra storage.
    assign flush = branch_taken_ex && !dmem_stall;

    // Register x0 is hard-wired to zero, so a load targeting it never feeds
    // a dependent instruction.
    assign r1_hit   = uses_r1_id && (r1_reg_idx_id == wr_reg_idx_ex);
    assign r2_hit   = uses_r2_id && (r2_reg_idx_id == wr_reg_idx_ex);
    assign load_use = mem_do_read_ctrl_ex && (wr_reg_idx_ex != 5'd0) && (r1_hit || r2_hit);

    // The stale fetch is consumed only when it actually arrives and nothing
    // more important owns the cycle.
    assign drop_done = drop_next && imem_ready && !dmem_stall && !flush && !load_use;

    // Next value of the wait counter for a stall cycle. Entering from RUN
    // starts the count at one; inside DMEM_WAIT it saturates at the timeout.
    always_comb begin
        wait_cnt_inc = 10'd1;
        if (state == DMEM_WAIT) begin
            if (wait_cnt == TIMEOUT_CNT) begin
                wait_cnt_inc = wait_cnt;
            end else begin
                wait_cnt_inc = wait_cnt + 10'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline control outputs
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the priority chain so no path
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_clear   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_clear   = 1'b0;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        mem_wb_clear  = 1'b0;

        if (!rst_n) begin
            // Hold everything and flush all bubbles while in reset.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            if_id_clear   = 1'b1;
            id_ex_enable  = 1'b0;
            id_ex_clear   = 1'b1;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            mem_wb_clear  = 1'b1;
        end else if (dmem_stall) begin
            // Freeze the whole pipe; WB receives a bubble so the stalled
            // MEM instruction is not retired twice.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            mem_wb_clear  = 1'b1;
        end else if (flush) begin
            // Redirect: load the target, kill the two younger instructions.
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID for one cycle and insert a single bubble into
            // EX; the load leaves EX on this edge so one bubble suffices.
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_clear  = 1'b1;
        end else if (!imem_ready) begin
            // No fetch data: keep the PC and feed a bubble into ID.
            pc_enable   = 1'b0;
            if_id_clear = 1'b1;
        end else if (drop_next) begin
            // Wrong-path response arrived: discard it and fetch onward.
            if_id_clear = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            drop_next    <= 1'b0;
            wait_cnt     <= 10'd0;
            dmem_timeout <= 1'b0;
        end else begin
            if (dmem_stall) begin
                state    <= DMEM_WAIT;
                wait_cnt <= wait_cnt_inc;
                if (wait_cnt_inc == TIMEOUT_CNT) begin
                    dmem_timeout <= 1'b1;
                end
            end else begin
                state    <= RUN;
                wait_cnt <= 10'd0;
            end

            // A redirect whose fetch has not returned leaves that fetch in
            // flight on the old path; a returned one was already cleared.
            if (flush) begin
                drop_next <= !imem_ready;
            end else if (drop_done) begin
                drop_next <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional performance counters
    // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_enable) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed sequence followed by random traffic. Expected outputs come from a
// reference model that classifies each cycle into one pipeline event and looks
// up the control pattern that event demands; wait cycles are counted with an
// unbounded integer and compared against the timeout threshold.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    // Control pattern order:
    // {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, mem_wb_en, mem_wb_clr}
    localparam logic [7:0] V_RESET = 8'b0010_1001;
    localparam logic [7:0] V_NONE  = 8'b1101_0110;
    localparam logic [7:0] V_DMEM  = 8'b0000_0001;
    localparam logic [7:0] V_FLUSH = 8'b1111_1110;
    localparam logic [7:0] V_LU    = 8'b0001_1110;
    localparam logic [7:0] V_IWAIT = 8'b0111_0110;
    localparam logic [7:0] V_DROP  = 8'b1111_0110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       r1_reg_idx_id, r2_reg_idx_id, wr_reg_idx_ex;
    logic             uses_r1_id, uses_r2_id, mem_do_read_ctrl_ex;
    logic             branch_taken_ex, dmem_req_mem, dmem_ready, imem_ready;
    logic             pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear;
    logic             ex_mem_enable, mem_wb_enable, mem_wb_clear, dmem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_drop;
    int          m_waits;
    bit          m_timeout;
    int unsigned m_stalls;
    int unsigned m_flushes;

    always #5 clk = ~clk;

    hazard_ctrl #(.DMEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r1_reg_idx_id       (r1_reg_idx_id),
        .r2_reg_idx_id       (r2_reg_idx_id),
        .uses_r1_id          (uses_r1_id),
        .uses_r2_id          (uses_r2_id),
        .mem_do_read_ctrl_ex (mem_do_read_ctrl_ex),
        .wr_reg_idx_ex       (wr_reg_idx_ex),
        .branch_taken_ex     (branch_taken_ex),
        .dmem_req_mem        (dmem_req_mem),
        .dmem_ready          (dmem_ready),
        .imem_ready          (imem_ready),
        .pc_enable           (pc_enable),
        .if_id_enable        (if_id_enable),
        .if_id_clear         (if_id_clear),
        .id_ex_enable        (id_ex_enable),
        .id_ex_clear         (id_ex_clear),
        .ex_mem_enable       (ex_mem_enable),
        .mem_wb_enable       (mem_wb_enable),
        .mem_wb_clear        (mem_wb_clear),
        .dmem_timeout        (dmem_timeout),
        .stall_count         (stall_count),
        .flush_count         (flush_count)
    );

    function automatic logic [7:0] obs_vec();
        return {pc_enable, if_id_enable, if_id_clear, id_ex_enable,
                id_ex_clear, ex_mem_enable, mem_wb_enable, mem_wb_clear};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_COUNTERS_EN
        check({tag, "/stall_count"}, stall_count, m_stalls);
        check({tag, "/flush_count"}, flush_count, m_flushes);
`else
        check({tag, "/stall_count"}, stall_count, 32'd0);
        check({tag, "/flush_count"}, flush_count, 32'd0);
`endif
    endtask

    task automatic model_reset();
        m_drop    = 1'b0;
        m_waits   = 0;
        m_timeout = 1'b0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    task automatic drive_idle();
        r1_reg_idx_id       = 5'd0;
        r2_reg_idx_id       = 5'd0;
        uses_r1_id          = 1'b0;
        uses_r2_id          = 1'b0;
        mem_do_read_ctrl_ex = 1'b0;
        wr_reg_idx_ex       = 5'd0;
        branch_taken_ex     = 1'b0;
        dmem_req_mem        = 1'b0;
        dmem_ready          = 1'b1;
        imem_ready          = 1'b1;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "/ctrl"}, obs_vec(), V_RESET);
        check({tag, "/timeout"}, dmem_timeout, 1'b0);
        check_counters(tag);
    endtask

    // One clock cycle: drive after the falling edge, check mid-low-phase,
    // then advance the model to the state it holds after the rising edge.
    task automatic step(input string tag,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic rd,
                        input logic [4:0] wr, input logic br,
                        input logic req, input logic rdy, input logic imr);
        bit         dm, lu;
        logic [7:0] exp;
        @(negedge clk);
        r1_reg_idx_id = r1; r2_reg_idx_id = r2; uses_r1_id = u1; uses_r2_id = u2;
        mem_do_read_ctrl_ex = rd; wr_reg_idx_ex = wr; branch_taken_ex = br;
        dmem_req_mem = req; dmem_ready = rdy; imem_ready = imr;
        #1;
        dm = req && !rdy;
        lu = rd && (wr != 5'd0) && ((u1 && r1 == wr) || (u2 && r2 == wr));
        if (dm)           exp = V_DMEM;
        else if (br)      exp = V_FLUSH;
        else if (lu)      exp = V_LU;
        else if (!imr)    exp = V_IWAIT;
        else if (m_drop)  exp = V_DROP;
        else              exp = V_NONE;
        check({tag, "/ctrl"}, obs_vec(), exp);
        check({tag, "/timeout"}, dmem_timeout, m_timeout);
        check_counters(tag);
        // Advance model
        if (dm) begin
            m_waits++;
            if (m_waits >= TO) m_timeout = 1'b1;
        end else begin
            m_waits = 0;
        end
        if (!dm && br) begin
            m_drop = !imr;
            m_flushes++;
        end else if (exp == V_DROP) begin
            m_drop = 1'b0;
        end
        if (exp[7] == 1'b0) m_stalls++;
    endtask

    task automatic idle(input string tag);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset_check("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First cycle out of reset, then perf-counter scenario:
        // two load-use stalls and one flush.
        idle("post_reset");
        step("lu_a", 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("lu_a_after");
        step("lu_b", 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("lu_b_after");
        step("flush_rdy", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle("flush_no_drop");
`ifdef HAZARD_PERF_COUNTERS_EN
        check("perf/stall_fixed", stall_count, 32'd2);
        check("perf/flush_fixed", flush_count, 32'd1);
`endif

        // Load into x0 and unused source never stall.
        step("lu_x0", 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("lu_unused", 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);

        // Branch while fetch is still outstanding: stale response dropped.
        step("flush_pend", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("imem_wait", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("drop");
        idle("drop_cleared");

        // Three-cycle data-memory stall with a branch held in EX.
        repeat (3) step("dstall_br", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("dstall_release", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle("after_release");

        // Timeout: six wait cycles, flag sets after the fourth and sticks.
        repeat (6) step("timeout_wait", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("timeout_release", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle("timeout_sticky");
        check("timeout_fixed", dmem_timeout, 1'b1);

        // Asynchronous reset in the middle of a wait clears the flag at once.
        repeat (2) step("wait_pre_rst", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        reset_check("async_reset");
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_async_reset");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
